// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: round-robin on ties, fixed 4-cycle
// transaction (IDLE -> ACCESS -> CAPTURE -> DONE) against a 1-cycle-latency memory.
module dmem_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req0_i,
    input  logic              req1_i,
    input  logic              wr0_i,
    input  logic              wr1_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              gnt0_o,
    output logic              gnt1_o,
    output logic              done0_o,
    output logic              done1_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic [ADDR_W-1:0] d_addr_o,
    output logic              d_wr_o,
    output logic [DATA_W-1:0] d_wdata_o,
    input  logic [DATA_W-1:0] d_rdata_i,
    output logic [7:0]        conflicts_o
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        CAPTURE,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              wr_q, wr_d;
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic              done0_q, done0_d;
    logic              done1_q, done1_d;
    logic              dwr_q, dwr_d;
    logic [ADDR_W-1:0] daddr_q, daddr_d;
    logic [DATA_W-1:0] dwdata_q, dwdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [7:0]        conf_q, conf_d;
    logic              win;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            wr_q     <= 1'b0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            dwr_q    <= 1'b0;
            daddr_q  <= '0;
            dwdata_q <= '0;
            rdata_q  <= '0;
            conf_q   <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            wr_q     <= wr_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            dwr_q    <= dwr_d;
            daddr_q  <= daddr_d;
            dwdata_q <= dwdata_d;
            rdata_q  <= rdata_d;
            conf_q   <= conf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        wr_d     = wr_q;
        gnt0_d   = gnt0_q;
        gnt1_d   = gnt1_q;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
        dwr_d    = 1'b0;
        daddr_d  = daddr_q;
        dwdata_d = dwdata_q;
        rdata_d  = rdata_q;
        conf_d   = conf_q;
        win      = last_q;

        case (state_q)
            IDLE: begin
                if (req0_i && req1_i && (conf_q != 8'hFF)) begin
                    conf_d = conf_q + 8'd1;
                end
                if (req0_i || req1_i) begin
                    // On a tie the requester not served last wins; otherwise the sole requester.
                    win      = (req0_i && req1_i) ? ~last_q : req1_i;
                    state_d  = ACCESS;
                    owner_d  = win;
                    last_d   = win;
                    wr_d     = win ? wr1_i : wr0_i;
                    dwr_d    = win ? wr1_i : wr0_i;
                    daddr_d  = win ? addr1_i : addr0_i;
                    dwdata_d = win ? wdata1_i : wdata0_i;
                    gnt0_d   = ~win;
                    gnt1_d   = win;
                end
            end
            ACCESS: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                state_d = DONE;
                done0_d = ~owner_q;
                done1_d = owner_q;
                if (!wr_q) begin
                    rdata_d = d_rdata_i;
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign gnt0_o      = gnt0_q;
    assign gnt1_o      = gnt1_q;
    assign done0_o     = done0_q;
    assign done1_o     = done1_q;
    assign rdata_o     = rdata_q;
    assign d_addr_o    = daddr_q;
    assign d_wr_o      = dwr_q;
    assign d_wdata_o   = dwdata_q;
    assign conflicts_o = conf_q;

    a_one_gnt : assert property (@(posedge clk_i) disable iff (!rst_ni) !(gnt0_q && gnt1_q));
    a_one_done : assert property (@(posedge clk_i) disable iff (!rst_ni) !(done0_q && done1_q));
    a_wr_access : assert property (@(posedge clk_i) disable iff (!rst_ni) dwr_q |-> (state_q == ACCESS));
    a_done_state : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    (done0_q || done1_q) |-> (state_q == DONE));

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, data-memory address width.
REQ-002 Parameter DATA_W, default 16, data-memory word width.
REQ-003 Clock  input  1  single clock; all state changes on rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 Req0/Req1  input  1 each  access request from requester 0 (processor control unit) / requester 1 (loader/debug port).
REQ-006 Wr0/Wr1  input  1 each  1 = write, 0 = read, for the matching requester.
REQ-007 Addr0/Addr1  input  ADDR_W each  word address for the matching requester.
REQ-008 WData0/WData1  input  DATA_W each  write data for the matching requester.
REQ-009 Gnt0/Gnt1  output  1 each  registered; high while that requester's transaction is in ACCESS, CAPTURE or DONE.
REQ-010 Done0/Done1  output  1 each  registered one-cycle completion pulse.
REQ-011 RData  output  DATA_W  registered read data for the last completed read; shared by both requesters.
REQ-012 D_addr  output  ADDR_W  memory address.
REQ-013 D_wr  output  1  memory write enable.
REQ-014 D_wdata  output  DATA_W  memory write data.
REQ-015 D_rdata  input  DATA_W  memory read data; valid the cycle after the address is presented.
REQ-016 Conflicts  output  8  saturating count of arbitration cycles with both requests high.

Function
REQ-017 FSM states IDLE, ACCESS, CAPTURE, DONE; transitions IDLE->ACCESS on any Req, ACCESS->CAPTURE, CAPTURE->DONE, and DONE->IDLE unconditionally.
REQ-018 In IDLE with exactly one Req high, that requester is granted at the next edge.
REQ-019 In IDLE with both Req high, the requester not served most recently is granted; the last-served flag updates on every grant.
REQ-020 On the grant edge, Wr/Addr/WData of the winner are latched; later changes to those inputs do not affect the transaction.
REQ-021 D_addr and D_wdata are driven from the latched values in ACCESS and CAPTURE, and held at last value otherwise.
REQ-022 D_wr is high for exactly the ACCESS cycle of a write and is low in all other cycles.
REQ-023 On the CAPTURE->DONE edge of a read, RData <= D_rdata; writes leave RData unchanged.
REQ-024 Done of the granted requester is high for exactly the DONE cycle; request-to-Done latency is 3 cycles (Req sampled at edge k, Done high in cycle k+3).
REQ-025 Gnt deasserts on the DONE->IDLE edge; never both Gnt high; never both Done high.
REQ-026 Requesters drop Req after seeing Done; a Req still high in IDLE is a new request.
REQ-027 Req deasserted by the granted requester before DONE does not abort; the transaction completes and Done still pulses.
REQ-028 A back-to-back requester holding Req continuously alternates with the other requester when both are pending (no starvation; worst-case wait 4 cycles after own request sampled).
REQ-029 Conflicts increments by 1 on each IDLE edge with Req0 = Req1 = 1, saturating at 255.

Reset
REQ-030 Reset low immediately forces state IDLE, Gnt0/Gnt1/Done0/Done1/D_wr = 0, D_addr/D_wdata/RData = 0, Conflicts = 0, and last-served = requester 1 (so requester 0 wins the first tie).
REQ-031 Reset asserted mid-transaction abandons it with no Done pulse; the first grant after reset release occurs at the first rising edge that samples Reset high and a Req high.

Verification
REQ-032 Req0 with Wr0=1, Addr0=0x10, WData0=0xBEEF -> D_wr high for one cycle with D_addr=0x10 and D_wdata=0xBEEF; Done0 high 3 cycles after the sample edge; RData unchanged.
REQ-033 Req1 read of Addr1=0x10 after REQ-032 -> RData=0xBEEF in the Done1 cycle; D_wr stays 0 throughout.
REQ-034 Req0 and Req1 raised in the same cycle after reset -> requester 0 served first; Conflicts=1; requester 1 Done follows 4 cycles after Done0.
REQ-035 Both requesters hold Req continuously for 8 transactions -> grants alternate 0,1,0,1...; Conflicts increments on each tied IDLE cycle; saturation verified at 255 after forced long run.
REQ-036 Addr0 and WData0 changed during ACCESS, plus Req0 dropped in CAPTURE -> memory sees the originally latched values and Done0 still pulses.
REQ-037 Reset pulsed low during the ACCESS cycle of a write -> D_wr=0 and all outputs=0 immediately; no Done; a fresh Req1 after release is granted normally.
